// File: rtl/dbg_pkg.sv
// Shared definitions for the register-file debug dumper: FSM state encoding,
// header sync byte and the byte-counter width helper.
package dbg_pkg;

    // Dumper FSM states; HDR is only visited when the header option is built in.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HOLD = 3'd1,
        LOAD = 3'd2,
        HDR  = 3'd3,
        SEND = 3'd4,
        FIN  = 3'd5
    } state_t;

    // First header byte sent ahead of every register payload.
    localparam logic [7:0] DUMP_SYNC = 8'hA5;

    // Width of a counter that indexes the bytes of a dataW-bit word (at least 1).
    function automatic int byteCntW(input int dataW);
        int n;
        n = dataW / 8;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_DATA_W = 32;
    localparam int BYTE_CNT_W = byteCntW(DEF_DATA_W);

endpackage

// File: rtl/word_serializer.sv
// Parallel-load word serializer: captures a DATA_W word and emits it as bytes
// over valid/ready, most significant byte first when MSB_FIRST=1, least
// significant byte first otherwise. 'last' flags the final byte of the word.
//
// Handshake: a byte transfers on every clk edge where valid && ready. Once
// valid is high it stays high and data stays stable until the byte is taken.
module word_serializer
    import dbg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic              launch,
    input  logic              ready,
    output logic              valid,
    output logic [7:0]        data,
    output logic              last
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CW     = byteCntW(DATA_W);

    logic [DATA_W-1:0] shiftReg;
    logic [CW-1:0]     byteCnt;

    // Load captures a fresh word; launch raises valid; each accepted byte shifts
    // the next one into the output position until the last one drops valid.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            shiftReg <= '0;
            byteCnt  <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            shiftReg <= word;
            byteCnt  <= '0;
            valid    <= launch;
        end else if (launch) begin
            valid <= 1'b1;
        end else if (valid && ready) begin
            if (last) begin
                valid <= 1'b0;
            end else begin
                byteCnt <= byteCnt + 1'b1;
                if (MSB_FIRST) shiftReg <= shiftReg << 8;
                else           shiftReg <= shiftReg >> 8;
            end
        end
    end

    // Output byte is a fixed slice of the shift register, so it is glitch-free.
    always_comb begin
        data = MSB_FIRST ? shiftReg[DATA_W-1 -: 8] : shiftReg[7:0];
        last = (byteCnt == CW'(NBYTES - 1));
    end

endmodule

// File: rtl/regfile_dumper.sv
// Debug reader for the CPU register file. A start pulse freezes the core via
// cpu_hold, walks addresses 0..NUM_REGS-1 through a spare read port and streams
// every word out as bytes over a valid/ready byte interface.
// Build option: define REGFILE_DUMP_HDR_EN to prefix each register payload
// with the two header bytes DUMP_SYNC, {0, rd_addr}.
//
// Handshake: a byte transfers on every clk edge where tx_valid && tx_ready.
// tx_valid never drops and tx_data never changes until the byte is accepted.
module regfile_dumper
    import dbg_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              cpu_hold,
    output logic              done,
    output state_t            dbgState
);

    state_t     state;
    logic       serLoad;
    logic       serLaunch;
    logic       serValid;
    logic [7:0] serData;
    logic       serLast;

    word_serializer #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk    (clk),
        .rstb   (rstb),
        .load   (serLoad),
        .word   (rd_data),
        .launch (serLaunch),
        .ready  (tx_ready),
        .valid  (serValid),
        .data   (serData),
        .last   (serLast)
    );

    assign serLoad  = (state == LOAD);
    assign dbgState = state;

`ifdef REGFILE_DUMP_HDR_EN
    logic       hdrValid;
    logic [7:0] hdrData;
    logic       hdrIdx;

    // Payload starts the cycle after the second header byte is accepted.
    assign serLaunch = (state == HDR) && hdrValid && tx_ready && hdrIdx;
    assign tx_valid  = hdrValid | serValid;
    assign tx_data   = hdrValid ? hdrData : serData;
`else
    // Payload starts right after the word is captured.
    assign serLaunch = (state == LOAD);
    assign tx_valid  = serValid;
    assign tx_data   = serData;
`endif

    // Dump sequencer: hold the core, step addresses, finish with a done pulse.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= IDLE;
            rd_addr  <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
`ifdef REGFILE_DUMP_HDR_EN
            hdrValid <= 1'b0;
            hdrData  <= '0;
            hdrIdx   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HOLD;
                        cpu_hold <= 1'b1;
                        rd_addr  <= '0;
                    end
                end
                HOLD: begin
                    state <= LOAD;
                end
                LOAD: begin
`ifdef REGFILE_DUMP_HDR_EN
                    hdrValid <= 1'b1;
                    hdrData  <= DUMP_SYNC;
                    hdrIdx   <= 1'b0;
                    state    <= HDR;
`else
                    state <= SEND;
`endif
                end
`ifdef REGFILE_DUMP_HDR_EN
                HDR: begin
                    if (hdrValid && tx_ready) begin
                        if (!hdrIdx) begin
                            hdrData <= 8'(rd_addr);
                            hdrIdx  <= 1'b1;
                        end else begin
                            hdrValid <= 1'b0;
                            state    <= SEND;
                        end
                    end
                end
`endif
                SEND: begin
                    if (serValid && tx_ready && serLast) begin
                        if (rd_addr == ADDR_W'(NUM_REGS - 1)) begin
                            state <= FIN;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                            state   <= LOAD;
                        end
                    end
                end
                FIN: begin
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                    rd_addr  <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: two instances (MSB-first and LSB-first) share one
// register-file array and one sink; their byte streams are scored against a
// queue built from the register contents.
module tb_regfile_dumper;
    import dbg_pkg::*;

    localparam int NREGS = 32;
`ifdef REGFILE_DUMP_HDR_EN
    localparam int HDR_B = 2;
`else
    localparam int HDR_B = 0;
`endif
    localparam int SEG_B = HDR_B + 4;
    localparam int PER   = 1 + SEG_B;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // ---------------- DUT wiring ----------------
    logic        start, tx_ready;
    logic [31:0] regs [NREGS];
    logic [4:0]  rdAddrM, rdAddrL;
    logic [31:0] rdDataM, rdDataL;
    logic        txValidM, txValidL, cpuHoldM, cpuHoldL, doneM, doneL;
    logic [7:0]  txDataM, txDataL;
    state_t      stateM, stateL;

    assign rdDataM = regs[rdAddrM];
    assign rdDataL = regs[rdAddrL];

    regfile_dumper #(.NUM_REGS(NREGS), .ADDR_W(5), .DATA_W(32), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rstb(rstb), .start(start), .rd_addr(rdAddrM), .rd_data(rdDataM),
        .tx_valid(txValidM), .tx_ready(tx_ready), .tx_data(txDataM),
        .cpu_hold(cpuHoldM), .done(doneM), .dbgState(stateM));

    regfile_dumper #(.NUM_REGS(NREGS), .ADDR_W(5), .DATA_W(32), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rstb(rstb), .start(start), .rd_addr(rdAddrL), .rd_data(rdDataL),
        .tx_valid(txValidL), .tx_ready(tx_ready), .tx_data(txDataL),
        .cpu_hold(cpuHoldL), .done(doneL), .dbgState(stateL));

    // ---------------- scoreboard ----------------
    int nChecks = 0;
    int nPass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] gotM[$];
    logic [7:0] gotL[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference stream: registers in address order, optional header, bytes in
    // the requested order.
    task automatic build_exp(input bit msbFirst);
        exp_q.delete();
        for (int r = 0; r < NREGS; r++) begin
            logic [31:0] w;
            w = regs[r];
`ifdef REGFILE_DUMP_HDR_EN
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(r));
`endif
            for (int b = 0; b < 4; b++) begin
                int idx;
                idx = msbFirst ? (3 - b) : b;
                exp_q.push_back(w[idx*8 +: 8]);
            end
        end
    endtask

    task automatic compare_stream(input string tag, input bit msbFirst);
        build_exp(msbFirst);
        if (msbFirst) begin
            check({tag, "_len_msb"}, gotM.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < gotM.size(); i++)
                check($sformatf("%s_msb[%0d]", tag, i), gotM[i], exp_q[i]);
        end else begin
            check({tag, "_len_lsb"}, gotL.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < gotL.size(); i++)
                check($sformatf("%s_lsb[%0d]", tag, i), gotL[i], exp_q[i]);
        end
    endtask

    // ---------------- monitor (samples on negedge) ----------------
    bit         monEn = 1'b0;
    int         startCyc, doneCnt, doneCyc, holdFirst, holdLast, holdCnt, firstValid;
    bit         prevStall;
    logic [7:0] prevData;

    always @(negedge clk) begin
        if (monEn) begin
            int cyc;
            cyc = cycleCnt - startCyc;
            if (prevStall) begin
                check("stall_valid", txValidM, 1'b1);
                check("stall_data", txDataM, prevData);
            end
            prevStall = txValidM && !tx_ready;
            prevData  = txDataM;
            if (txValidM && firstValid < 0) firstValid = cyc;
            if (txValidM && tx_ready) gotM.push_back(txDataM);
            if (txValidL && tx_ready) gotL.push_back(txDataL);
            if (doneM) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (cpuHoldM) begin
                if (holdFirst < 0) holdFirst = cyc;
                holdLast = cyc;
                holdCnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int stallLeft = 0;
    bit midDone;

    task automatic drive_ready(input int stallPct);
        if (stallLeft > 0) begin
            tx_ready  = 1'b0;
            stallLeft = stallLeft - 1;
        end else if (stallPct > 0 && $urandom_range(0, 99) < stallPct) begin
            stallLeft = $urandom_range(0, 5);
            tx_ready  = (stallLeft == 0);
            if (stallLeft > 0) stallLeft = stallLeft - 1;
        end else begin
            tx_ready = 1'b1;
        end
    endtask

    task automatic run_dump(input int stallPct, input bit midStart);
        gotM.delete();
        gotL.delete();
        doneCnt = 0; doneCyc = -1; holdFirst = -1; holdLast = -1; holdCnt = 0;
        firstValid = -1; prevStall = 1'b0; stallLeft = 0; midDone = 1'b0;
        @(posedge clk); #1;
        start    = 1'b1;
        startCyc = cycleCnt;
        drive_ready(stallPct);
        monEn = 1'b1;
        for (int n = 0; n < 5000 && doneCnt == 0; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (midStart && !midDone && rdAddrM == 5'd10) begin
                start   = 1'b1;
                midDone = 1'b1;
            end
            drive_ready(stallPct);
        end
        if (doneCnt == 0) check("done_timeout", 32'd0, 32'd1);
        start    = 1'b0;
        tx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        monEn = 1'b0;
    endtask

    task automatic check_timing(input string tag);
        check({tag, "_done_cyc"}, doneCyc, 2 + NREGS*PER + 1);
        check({tag, "_hold_first"}, holdFirst, 1);
        check({tag, "_hold_last"}, holdLast, 2 + NREGS*PER);
        check({tag, "_first_valid"}, firstValid, 3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        start = 1'b0; tx_ready = 1'b1; rstb = 1'b0;
        for (int r = 0; r < NREGS; r++) regs[r] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_addr", rdAddrM, 5'd0);
        check("rst_tx_valid", txValidM, 1'b0);
        check("rst_tx_data", txDataM, 8'd0);
        check("rst_cpu_hold", cpuHoldM, 1'b0);
        check("rst_done", doneM, 1'b0);
        check("rst_state", stateM, IDLE);
        rstb = 1'b1;
        repeat (2) @(posedge clk);

        // All-zero register file, sink always ready.
        run_dump(0, 1'b0);
        check_timing("zero");
        check("zero_done_cnt", doneCnt, 1);
        check("zero_hold_cnt", holdCnt, 2 + NREGS*PER);
        compare_stream("zero", 1'b1);

        // Preloaded values plus random fill, both byte orders.
        for (int r = 0; r < NREGS; r++) regs[r] = $urandom;
        regs[0]  = 32'd0;
        regs[1]  = 32'h12345678;
        regs[2]  = 32'hCAFEF00D;
        regs[31] = 32'hDEADBEEF;
        run_dump(0, 1'b0);
        check_timing("pre");
        compare_stream("pre", 1'b1);
        compare_stream("pre", 1'b0);
        check("r1_msb_b0", gotM[SEG_B + HDR_B + 0], 8'h12);
        check("r1_msb_b3", gotM[SEG_B + HDR_B + 3], 8'h78);
        check("r1_lsb_b0", gotL[SEG_B + HDR_B + 0], 8'h78);
        check("r1_lsb_b3", gotL[SEG_B + HDR_B + 3], 8'h12);
        check("r31_msb_b0", gotM[NREGS*SEG_B - 4], 8'hDE);
        check("r31_msb_b3", gotM[NREGS*SEG_B - 1], 8'hEF);
`ifdef REGFILE_DUMP_HDR_EN
        check("r2_hdr0", gotM[2*SEG_B + 0], 8'hA5);
        check("r2_hdr1", gotM[2*SEG_B + 1], 8'h02);
        check("r2_b0", gotM[2*SEG_B + 2], 8'hCA);
        check("r2_b3", gotM[2*SEG_B + 5], 8'h0D);
`endif

        // Random sink stalls: same stream, stable data while stalled.
        for (int r = 1; r < NREGS; r++) regs[r] = $urandom;
        run_dump(40, 1'b0);
        check("stall_done_cnt", doneCnt, 1);
        check("stall_hold_cont", holdCnt, doneCyc - 1);
        compare_stream("stall", 1'b1);
        compare_stream("stall", 1'b0);

        // Second start pulse while register 10 is being dumped is ignored.
        run_dump(20, 1'b1);
        check("mid_start_fired", midDone, 1'b1);
        check("mid_done_cnt", doneCnt, 1);
        compare_stream("mid", 1'b1);

        // Asynchronous reset while rd_addr is 7 aborts the dump.
        @(posedge clk); #1;
        start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 500 && rdAddrM != 5'd7; n++) begin
            @(posedge clk); #1;
        end
        check("abort_reached_r7", rdAddrM, 5'd7);
        #2;
        rstb = 1'b0;
        #1;
        check("abort_tx_valid", txValidM, 1'b0);
        check("abort_cpu_hold", cpuHoldM, 1'b0);
        check("abort_done", doneM, 1'b0);
        check("abort_rd_addr", rdAddrM, 5'd0);
        check("abort_state", stateM, IDLE);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", doneM, 1'b0);
        rstb = 1'b1;
        repeat (2) @(posedge clk);
        run_dump(0, 1'b0);
        check_timing("post");
        check("post_done_cnt", doneCnt, 1);
        compare_stream("post", 1'b1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
